// File: rtl/magnetron_power_ctrl.sv
// -----------------------------------------------------------------------------
// magnetron_power_ctrl
//
// Purpose:
//   Cooking-cycle controller for a microwave magnetron. A four-state machine
//   (IDLE / COOK / PAUSED / DONE) is driven by the front-panel requests and the
//   door interlock. While cooking, the magnetron is time-proportioned: it is on
//   for lvl_q out of every PERIOD cycles. The countdown-timer enable and a
//   completion pulse are also produced here.
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        synchronous active-high reset
//   startn       in   1        start/resume request, active low
//   stopn        in   1        pause request, active low
//   clearn       in   1        cancel/clear request, active low
//   door_closed  in   1        door interlock, 1 = closed
//   timer_done   in   1        cook timer expired (level)
//   power_level  in   LEVEL_W  requested on-cycles per window (clamped to PERIOD)
//   mag_on       out  1        magnetron drive (gated by door_closed)
//   timer_en     out  1        high while in COOK
//   done_pulse   out  1        one-cycle pulse on entry to DONE
//   state        out  2        00 IDLE, 01 COOK, 10 PAUSED, 11 DONE
// -----------------------------------------------------------------------------
module magnetron_power_ctrl #(
    parameter int PERIOD  = 10,
    parameter int PHASE_W = 4,
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               timer_done,
    input  logic [LEVEL_W-1:0] power_level,
    output logic               mag_on,
    output logic               timer_en,
    output logic               done_pulse,
    output logic [1:0]         state
);

    // One extra bit so the latched level can hold the value PERIOD itself.
    localparam int LVL_W = PHASE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COOK   = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic [LVL_W-1:0]   r_lvl;
    logic [LVL_W-1:0]   w_lvl_next;
    logic [LVL_W-1:0]   w_lvl_clamped;
    logic               r_mag;
    logic               w_mag_next;
    logic               r_done_pulse;
    logic               w_done_next;
    logic               w_cook_entry;

    // Requested levels above PERIOD mean full power.
    assign w_lvl_clamped = (int'(power_level) > PERIOD) ? LVL_W'(PERIOD)
                                                        : LVL_W'(power_level);

    // Next-state logic. Priority: clear > door open > timer_done > stop > start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clearn && door_closed && !timer_done && stopn && !startn)
                    w_state_next = ST_COOK;
            end
            ST_COOK: begin
                if (!clearn)
                    w_state_next = ST_IDLE;
                else if (!door_closed)
                    w_state_next = ST_PAUSED;
                else if (timer_done)
                    w_state_next = ST_DONE;
                else if (!stopn)
                    w_state_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                // timer_done is deliberately ignored: the timer is frozen here.
                if (!clearn)
                    w_state_next = ST_IDLE;
                else if (door_closed && stopn && !startn)
                    w_state_next = ST_COOK;
            end
            ST_DONE: begin
                if (!clearn || !door_closed)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Phase and level datapath, plus registered output terms.
    always_comb begin
        w_cook_entry = (w_state_next == ST_COOK) && (r_state != ST_COOK);
        w_lvl_next   = r_lvl;
        w_phase_next = r_phase;
        if (w_cook_entry) begin
            // Every (re)entry restarts the window and samples a fresh level.
            w_phase_next = '0;
            w_lvl_next   = w_lvl_clamped;
        end else if (r_state == ST_COOK) begin
            w_phase_next = (r_phase == PHASE_W'(PERIOD - 1)) ? '0
                                                              : r_phase + PHASE_W'(1);
        end
        w_mag_next  = (w_state_next == ST_COOK) && ({1'b0, w_phase_next} < w_lvl_next);
        w_done_next = (w_state_next == ST_DONE) && (r_state != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_lvl        <= '0;
            r_mag        <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_phase      <= w_phase_next;
            r_lvl        <= w_lvl_next;
            r_mag        <= w_mag_next;
            r_done_pulse <= w_done_next;
        end
    end

    // The door gate is combinational so an opening door cuts the drive
    // in the same cycle, independent of the registered state.
    assign mag_on     = r_mag & door_closed;
    assign timer_en   = (r_state == ST_COOK);
    assign done_pulse = r_done_pulse;
    assign state      = r_state;

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
module tb_magnetron_power_ctrl;

    localparam int PERIOD = 10;
    localparam int M_IDLE = 0, M_COOK = 1, M_PAUSED = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic       door_closed = 1'b1, timer_done = 1'b0;
    logic [3:0] power_level = 4'd0;
    logic       mag_on, timer_en, done_pulse;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int on_cnt = 0;

    // Reference model: cycles spent in the current cook run, not a phase register.
    int m_st   = M_IDLE;
    int m_cyc  = 0;
    int m_lvl  = 0;
    int m_mag  = 0;
    int m_done = 0;

    magnetron_power_ctrl #(.PERIOD(10), .PHASE_W(4), .LEVEL_W(4)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done),
        .power_level(power_level), .mag_on(mag_on), .timer_en(timer_en),
        .done_pulse(done_pulse), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int st, input logic s, input logic sp,
                                      input logic c, input logic d, input logic td);
        if (!c)       return M_IDLE;
        if (!d)       return (st == M_COOK) ? M_PAUSED : (st == M_DONE) ? M_IDLE : st;
        case (st)
            M_COOK:   return td ? M_DONE : (!sp ? M_PAUSED : M_COOK);
            M_IDLE:   return (!td && sp && !s) ? M_COOK : M_IDLE;
            M_PAUSED: return (sp && !s) ? M_COOK : M_PAUSED;
            default:  return M_DONE;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check the combinational door gate,
    // advance the model at posedge, check all outputs shortly after.
    task automatic step(input logic s, input logic sp, input logic c, input logic d,
                        input logic td, input int pl, input logic r, input string tag);
        int ns;
        @(negedge clk);
        startn = s; stopn = sp; clearn = c; door_closed = d; timer_done = td;
        power_level = 4'(pl); rst = r;
        #1;
        chk({tag, "_pre_mag"}, int'(mag_on), m_mag & int'(d));
        @(posedge clk);
        if (r) begin
            m_st = M_IDLE; m_mag = 0; m_done = 0; m_lvl = 0; m_cyc = 0;
        end else begin
            ns = model_next(m_st, s, sp, c, d, td);
            if (ns == M_COOK && m_st != M_COOK) begin
                m_lvl = (pl > PERIOD) ? PERIOD : pl;
                m_cyc = 0;
            end else if (ns == M_COOK) begin
                m_cyc++;
            end
            m_mag  = (ns == M_COOK && (m_cyc % PERIOD) < m_lvl) ? 1 : 0;
            m_done = (ns == M_DONE && m_st != M_DONE) ? 1 : 0;
            m_st   = ns;
        end
        #1;
        chk({tag, "_state"}, int'(state), m_st);
        chk({tag, "_timer_en"}, int'(timer_en), (m_st == M_COOK) ? 1 : 0);
        chk({tag, "_done"}, int'(done_pulse), m_done);
        chk({tag, "_mag"}, int'(mag_on), m_mag & int'(d));
        if (mag_on) on_cnt++;
        $display("step %-6s rst=%0b st=%0b sp=%0b cl=%0b door=%0b td=%0b pl=%0d -> state=%0d mag=%0b ten=%0b dp=%0b",
                 tag, r, s, sp, c, d, td, pl, state, mag_on, timer_en, done_pulse);
    endtask

    initial begin
        // Reset
        step(1, 1, 1, 1, 0, 0, 1, "rst");
        step(1, 1, 1, 1, 0, 0, 1, "rst");
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({mag_on, timer_en, done_pulse}), 0);

        // T1: level 7 -> 7 on / 3 off per window
        step(0, 1, 1, 1, 0, 7, 0, "T1");
        chk("T1_first_mag", int'(mag_on), 1);
        on_cnt = 0;
        for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0, 7, 0, "T1");
        chk("T1_on_count", on_cnt, 14);

        // T2: restart, open door at phase 3
        step(1, 1, 0, 1, 0, 7, 0, "T2clr");
        step(0, 1, 1, 1, 0, 7, 0, "T2");
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 7, 0, "T2");
        step(1, 1, 1, 0, 0, 7, 0, "T2door");
        chk("T2_paused", int'(state), 2);
        step(1, 1, 1, 1, 0, 7, 0, "T2");
        step(0, 1, 1, 1, 0, 7, 0, "T2res");
        chk("T2_recook", int'(state), 1);
        on_cnt = 0;
        for (int i = 0; i < 9; i++) step(1, 1, 1, 1, 0, 7, 0, "T2");
        chk("T2_phase_restart", on_cnt, 6);

        // T3: timer_done in COOK -> DONE, startn ignored, clearn -> IDLE
        step(1, 1, 1, 1, 1, 7, 0, "T3");
        chk("T3_done_pulse", int'(done_pulse), 1);
        step(0, 1, 1, 1, 1, 7, 0, "T3");
        chk("T3_pulse_once", int'(done_pulse), 0);
        chk("T3_stay_done", int'(state), 3);
        step(1, 1, 0, 1, 0, 7, 0, "T3");
        chk("T3_idle", int'(state), 0);

        // T4: level 0 and level 15
        step(0, 1, 1, 1, 0, 0, 0, "T4a");
        on_cnt = 0;
        for (int i = 0; i < 12; i++) step(1, 1, 1, 1, 0, 9, 0, "T4a");
        chk("T4_level0", on_cnt, 0);
        step(1, 1, 0, 1, 0, 0, 0, "T4clr");
        step(0, 1, 1, 1, 0, 15, 0, "T4b");
        on_cnt = 0;
        for (int i = 0; i < 12; i++) step(1, 1, 1, 1, 0, 2, 0, "T4b");
        chk("T4_level15", on_cnt, 12);

        // T5: clear + timer_done together; start with door open in IDLE
        step(1, 1, 0, 1, 1, 5, 0, "T5");
        chk("T5_no_done", int'(done_pulse), 0);
        step(0, 1, 1, 0, 0, 5, 0, "T5door");
        chk("T5_idle", int'(state), 0);

        // stop+start together in COOK -> PAUSED, then start -> COOK
        step(0, 1, 1, 1, 0, 5, 0, "SS");
        step(0, 0, 1, 1, 0, 5, 0, "SS");
        chk("SS_paused", int'(state), 2);
        step(0, 1, 1, 1, 0, 5, 0, "SS");
        chk("SS_cook", int'(state), 1);

        // T6: rst mid-COOK with startn held low
        step(0, 1, 1, 1, 0, 8, 1, "T6rst");
        chk("T6_idle", int'({state, mag_on, timer_en, done_pulse}), 0);
        step(0, 1, 1, 1, 0, 8, 0, "T6");
        chk("T6_cook", int'(state), 1);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) >= 3, $urandom_range(0, 99) >= 8,
                 $urandom_range(0, 99) >= 4, $urandom_range(0, 99) >= 8,
                 $urandom_range(0, 99) < 5, int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 2, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
